// File: rtl/stn_scan_ctrl.sv
// Dual-scan colour STN frame sequencer: FRC frame trigger, FIFO drain at pixel rate, CP/LP/FLM/M timing.
// Optional: define STN_UNDERRUN_CNT_EN to add a saturating 16-bit underrun_cnt output.
module stn_scan_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 240,
  parameter int H_BLANK  = 16,
  parameter int V_BLANK  = 4,
  parameter int CLK_DIV  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       frc_trigger,
  output logic       fifo_re,
  input  logic [5:0] fifo_data,
  input  logic       fifo_empty,
  output logic       lcd_cp,
  output logic       lcd_lp,
  output logic       lcd_flm,
  output logic       lcd_m,
  output logic [2:0] lcd_ud,
  output logic [2:0] lcd_ld,
  output logic       scanning,
`ifdef STN_UNDERRUN_CNT_EN
  output logic [15:0] underrun_cnt,
`endif
  output logic       underrun
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_ACTIVE + V_BLANK;
  localparam int XW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int YW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VBLANK = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          trig_q, trig_d;
  logic          m_q, m_d;
  logic          starve_q;
  logic          underrun_q;
  logic [2:0]    ud_q, ld_q;

  logic tick, x_wrap, y_last, running, data_ph, pop_slot, load_slot;

  assign running   = (state_q != S_IDLE);
  assign tick      = (div_q == DW'(CLK_DIV - 1));
  assign x_wrap    = tick && (x_q == XW'(H_TOTAL - 1));
  assign y_last    = (y_q == YW'(V_TOTAL - 1));
  assign data_ph   = (state_q == S_ACTIVE) && (x_q < XW'(H_ACTIVE));
  assign pop_slot  = data_ph && (div_q == '0);
  assign load_slot = data_ph && (div_q == DW'(1));

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    x_d     = x_q;
    y_d     = y_q;
    trig_d  = 1'b0;
    m_d     = m_q;
    case (state_q)
      S_IDLE: begin
        div_d = '0;
        x_d   = '0;
        y_d   = '0;
        if (enable) begin
          state_d = S_VBLANK;
          y_d     = YW'(V_ACTIVE);
          trig_d  = 1'b1;
        end
      end
      default: begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (tick) begin
          x_d = x_wrap ? '0 : x_q + 1'b1;
        end
        if (x_wrap) begin
          if (y_last) begin
            // Frame boundary: the only place enable is looked at while scanning.
            y_d     = '0;
            m_d     = ~m_q;
            state_d = enable ? S_ACTIVE : S_IDLE;
          end else begin
            y_d = y_q + 1'b1;
            if ((state_q == S_ACTIVE) && (y_q == YW'(V_ACTIVE - 1))) begin
              state_d = S_VBLANK;
              trig_d  = 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      trig_q  <= 1'b0;
      m_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      x_q     <= x_d;
      y_q     <= y_d;
      trig_q  <= trig_d;
      m_q     <= m_d;
    end
  end

  // The FIFO word arrives one clk after the pop; a starved slot forces zero data instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q   <= 1'b0;
      underrun_q <= 1'b0;
      ud_q       <= '0;
      ld_q       <= '0;
    end else begin
      if (pop_slot) begin
        starve_q <= fifo_empty;
        if (fifo_empty) begin
          underrun_q <= 1'b1;
        end
      end
      if (load_slot) begin
        ud_q <= starve_q ? 3'b000 : fifo_data[5:3];
        ld_q <= starve_q ? 3'b000 : fifo_data[2:0];
      end
    end
  end

`ifdef STN_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ucnt_q <= '0;
    end else if (pop_slot && fifo_empty && (ucnt_q != 16'hFFFF)) begin
      ucnt_q <= ucnt_q + 16'd1;
    end
  end

  assign underrun_cnt = ucnt_q;
`endif

  assign frc_trigger = trig_q;
  assign fifo_re     = pop_slot && !fifo_empty;
  assign lcd_cp      = data_ph && (div_q >= DW'(CLK_DIV / 2));
  assign lcd_lp      = running && (x_q == XW'(H_ACTIVE + 1));
  assign lcd_flm     = lcd_lp && (y_q == '0);
  assign lcd_m       = m_q;
  assign lcd_ud      = ud_q;
  assign lcd_ld      = ld_q;
  assign scanning    = running;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_stn_scan_ctrl.sv
// Randomised self-checking bench for stn_scan_ctrl against a frame-arithmetic reference model.
// Build with STN_UNDERRUN_CNT_EN defined to also check the underrun counter.
module tb_stn_scan_ctrl;

  localparam int HA = 8;
  localparam int VA = 2;
  localparam int HB = 4;
  localparam int VB = 2;
  localparam int CD = 4;
  localparam int HT = HA + HB;
  localparam int VT = VA + VB;
  localparam int LINE_CLK  = HT * CD;
  localparam int FRAME_CLK = LINE_CLK * VT;
  localparam int L0 = VB * LINE_CLK;  // offset of line y==0 within a frame, counted from the trigger

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       frc_trigger, fifo_re, fifo_empty;
  logic [5:0] fifo_data;
  logic       lcd_cp, lcd_lp, lcd_flm, lcd_m, scanning, underrun;
  logic [2:0] lcd_ud, lcd_ld;
`ifdef STN_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  stn_scan_ctrl #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .V_BLANK(VB), .CLK_DIV(CD)
  ) dut (
`ifdef STN_UNDERRUN_CNT_EN
    .underrun_cnt(underrun_cnt),
`endif
    .clk(clk), .rst(rst), .enable(enable),
    .frc_trigger(frc_trigger), .fifo_re(fifo_re),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .lcd_cp(lcd_cp), .lcd_lp(lcd_lp), .lcd_flm(lcd_flm), .lcd_m(lcd_m),
    .lcd_ud(lcd_ud), .lcd_ld(lcd_ld), .scanning(scanning), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n = 0;
  logic m_base;
  logic empty_plan = 1'b0;
  logic fixed_en = 1'b0;
  logic pop_pend = 1'b0;
  logic [5:0] pop_word = '0;
  logic s_trig, s_re, s_cp, s_lp, s_flm, s_m, s_scan, s_und;
  logic [2:0] s_ud, s_ld;

  // Expected {trig, re, cp, lp, flm, m, scanning} at cycle nn after a trigger, FIFO never empty.
  function automatic logic [6:0] exp_vec(input int nn, input logic mb);
    int g, y, p, d;
    logic act, lp;
    g   = nn / LINE_CLK;
    y   = (g + VA) % VT;
    p   = (nn % LINE_CLK) / CD;
    d   = nn % CD;
    act = (y < VA) && (p < HA);
    lp  = (p == HA + 1);
    return {(nn % FRAME_CLK) == 0, act && (d == 0), act && (d >= CD / 2), lp,
            lp && (y == 0), mb ^ 1'(((g + VA) / VT) % 2), 1'b1};
  endfunction

  // One clk: FIFO model presents the popped word, empty flag applied, outputs sampled.
  task automatic step();
    @(posedge clk);
    #1;
    if (pop_pend) fifo_data = pop_word;
    fifo_empty = empty_plan;
    #1;
    n++;
    s_trig = frc_trigger; s_re = fifo_re; s_cp = lcd_cp; s_lp = lcd_lp;
    s_flm = lcd_flm; s_m = lcd_m; s_scan = scanning; s_und = underrun;
    s_ud = lcd_ud; s_ld = lcd_ld;
    pop_pend = fifo_re;
    if (fifo_re) pop_word = fixed_en ? 6'b101010 : 6'($urandom);
  endtask

  task automatic wait_trigger();
    int k;
    k = 0;
    step();
    while (!s_trig && k < 10) begin
      step();
      k++;
    end
    checks++;
    if (!s_trig) begin
      errors++;
      $display("FAIL trigger_wait got=0 exp=1 within 10 clk");
    end
    n = 0;
    m_base = s_m;
  endtask

  task automatic test_reset();
    logic [13:0] v;
    rst = 1'b1; enable = 1'b0; fifo_empty = 1'b0; fifo_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    v = {frc_trigger, fifo_re, lcd_cp, lcd_lp, lcd_flm, lcd_m, scanning, underrun, lcd_ud, lcd_ld};
    checks++;
    if (v !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=0", v);
    end
`ifdef STN_UNDERRUN_CNT_EN
    checks++;
    if (underrun_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt got=%0d exp=0", underrun_cnt);
    end
`endif
    repeat (5) step();
    checks++;
    if ({s_scan, s_trig, s_lp} !== 3'b000) begin
      errors++;
      $display("FAIL idle_hold got=%b exp=000", {s_scan, s_trig, s_lp});
    end
  endtask

  task automatic test_frames();
    logic [6:0] ev, av;
    logic [5:0] exp_pix;
    logic prev_cp, prev_m;
    int trigs, mtog, pops, cps, exp_cnt;
    fixed_en = 1'b0; empty_plan = 1'b0; enable = 1'b1;
    wait_trigger();
    trigs = 0; mtog = 0; pops = 0; cps = 0; prev_cp = 1'b0; prev_m = s_m; exp_pix = '0;
    for (int i = 0; i < 3 * FRAME_CLK; i++) begin
      if (i > 0) step();
      ev = exp_vec(n, m_base);
      av = {s_trig, s_re, s_cp, s_lp, s_flm, s_m, s_scan};
      checks++;
      if (av !== ev) begin
        errors++;
        $display("FAIL frames_ctrl n=%0d got=%b exp=%b", n, av, ev);
      end
      checks++;
      if (s_trig && s_re) begin
        errors++;
        $display("FAIL trig_re_overlap n=%0d got=11 exp=not both", n);
      end
      if (s_re) exp_pix = pop_word;
      if (ev[4] && (n % CD == CD - 1)) begin
        checks++;
        if ({s_ud, s_ld} !== exp_pix) begin
          errors++;
          $display("FAIL frames_data n=%0d got=%b exp=%b", n, {s_ud, s_ld}, exp_pix);
        end
      end
      if (s_trig) trigs++;
      if (s_m != prev_m) mtog++;
      prev_m = s_m;
      if (s_re) pops++;
      if (s_cp && !prev_cp) cps++;
      prev_cp = s_cp;
      if (n % LINE_CLK == LINE_CLK - 1) begin
        exp_cnt = ((((n / LINE_CLK) + VA) % VT) < VA) ? HA : 0;
        checks++;
        if (pops != exp_cnt || cps != exp_cnt) begin
          errors++;
          $display("FAIL line_counts n=%0d got pops=%0d cps=%0d exp=%0d", n, pops, cps, exp_cnt);
        end
        pops = 0; cps = 0;
      end
    end
    checks++;
    if (trigs != 3 || mtog != 3) begin
      errors++;
      $display("FAIL frame_totals got trig=%0d mtog=%0d exp=3,3", trigs, mtog);
    end
    checks++;
    if (s_und !== 1'b0) begin
      errors++;
      $display("FAIL frames_no_underrun got=%b exp=0", s_und);
    end
  endtask

  task automatic test_pattern();
    logic [6:0] ev;
    fixed_en = 1'b1;
    for (int i = 0; i < FRAME_CLK; i++) begin
      step();
      ev = exp_vec(n, m_base);
      checks++;
      if ({s_trig, s_re, s_cp, s_lp, s_flm, s_m, s_scan} !== ev) begin
        errors++;
        $display("FAIL pattern_ctrl n=%0d got=%b exp=%b", n, {s_trig, s_re, s_cp, s_lp, s_flm, s_m, s_scan}, ev);
      end
      if (s_cp) begin
        checks++;
        if (s_ud !== 3'b101 || s_ld !== 3'b010) begin
          errors++;
          $display("FAIL pattern_data n=%0d got ud=%b ld=%b exp ud=101 ld=010", n, s_ud, s_ld);
        end
      end
    end
    fixed_en = 1'b0;
  endtask

  task automatic test_disable();
    logic [6:0] ev;
    int n_idle;
    for (int i = 0; i < FRAME_CLK && (n % FRAME_CLK) != L0 + 4 * CD; i++) step();
    checks++;
    if ((n % FRAME_CLK) != L0 + 4 * CD) begin
      errors++;
      $display("FAIL disable_reach got=%0d exp=%0d", n % FRAME_CLK, L0 + 4 * CD);
    end
    enable = 1'b0;
    n_idle = n - (n % FRAME_CLK) + FRAME_CLK + L0;
    while (n < n_idle + 40) begin
      step();
      if (n < n_idle) begin
        ev = exp_vec(n, m_base);
        checks++;
        if ({s_trig, s_re, s_cp, s_lp, s_flm, s_m, s_scan} !== ev) begin
          errors++;
          $display("FAIL disable_tail n=%0d got=%b exp=%b", n, {s_trig, s_re, s_cp, s_lp, s_flm, s_m, s_scan}, ev);
        end
      end else begin
        ev = exp_vec(n_idle, m_base);
        checks++;
        if ({s_trig, s_re, s_cp, s_lp, s_flm, s_scan} !== 6'd0 || s_m !== ev[1]) begin
          errors++;
          $display("FAIL disable_idle n=%0d got=%b m=%b exp=0 m=%b", n, {s_trig, s_re, s_cp, s_lp, s_flm, s_scan}, s_m, ev[1]);
        end
      end
    end
  endtask

  task automatic test_underrun();
    logic [6:0] ev;
    logic [5:0] exp_pix;
    logic starved, prev_cp;
    int k2, g, p, d, nn, pops, cps;
    k2 = int'($urandom_range(0, HA - 1));
    empty_plan = 1'b0; enable = 1'b1;
    wait_trigger();
    exp_pix = '0; pops = 0; cps = 0; prev_cp = 1'b0;
    for (int i = 1; i < FRAME_CLK; i++) begin
      nn = n + 1;
      g = nn / LINE_CLK; p = (nn % LINE_CLK) / CD; d = nn % CD;
      starved = (g == VB && p == 3) || (g == VB + 1 && p == k2);
      if (starved) empty_plan = 1'b1;
      else if (g >= VB && p < HA && d == 0) empty_plan = 1'b0;
      else empty_plan = 1'($urandom % 2);
      step();
      ev = exp_vec(n, m_base);
      if (starved && d == 0) ev[5] = 1'b0;
      checks++;
      if ({s_trig, s_re, s_cp, s_lp, s_flm, s_m, s_scan} !== ev) begin
        errors++;
        $display("FAIL underrun_ctrl n=%0d got=%b exp=%b", n, {s_trig, s_re, s_cp, s_lp, s_flm, s_m, s_scan}, ev);
      end
      if (g >= VB && p < HA && d == 0) exp_pix = starved ? 6'd0 : pop_word;
      if (ev[4] && d == CD - 1) begin
        checks++;
        if ({s_ud, s_ld} !== exp_pix) begin
          errors++;
          $display("FAIL underrun_data n=%0d got=%b exp=%b", n, {s_ud, s_ld}, exp_pix);
        end
      end
      checks++;
      if (s_und !== (n > L0 + 3 * CD)) begin
        errors++;
        $display("FAIL underrun_flag n=%0d got=%b exp=%b", n, s_und, n > L0 + 3 * CD);
      end
      if (g == VB) begin
        if (s_re) pops++;
        if (s_cp && !prev_cp) cps++;
      end
      prev_cp = s_cp;
    end
    empty_plan = 1'b0;
    checks++;
    if (pops != HA - 1 || cps != HA) begin
      errors++;
      $display("FAIL underrun_line0 got pops=%0d cps=%0d exp pops=%0d cps=%0d", pops, cps, HA - 1, HA);
    end
`ifdef STN_UNDERRUN_CNT_EN
    checks++;
    if (underrun_cnt !== 16'd2) begin
      errors++;
      $display("FAIL underrun_cnt got=%0d exp=2", underrun_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [13:0] v;
    logic [6:0] ev;
    for (int i = 0; i < 2 * FRAME_CLK && (n % FRAME_CLK) != L0 + 5 * CD; i++) step();
    checks++;
    if ((n % FRAME_CLK) != L0 + 5 * CD || s_scan !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_reach got=%0d scan=%b exp=%0d scan=1", n % FRAME_CLK, s_scan, L0 + 5 * CD);
    end
    rst = 1'b1;
    #1;
    v = {frc_trigger, fifo_re, lcd_cp, lcd_lp, lcd_flm, lcd_m, scanning, underrun, lcd_ud, lcd_ld};
    checks++;
    if (v !== 14'd0) begin
      errors++;
      $display("FAIL rstmid_outputs got=%b exp=0", v);
    end
`ifdef STN_UNDERRUN_CNT_EN
    checks++;
    if (underrun_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_cnt got=%0d exp=0", underrun_cnt);
    end
`endif
    fifo_data = '0; pop_pend = 1'b0; empty_plan = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    wait_trigger();
    checks++;
    if (m_base !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_m got=%b exp=0", m_base);
    end
    for (int i = 1; i <= L0 + 4; i++) begin
      step();
      ev = exp_vec(n, m_base);
      checks++;
      if ({s_trig, s_re, s_cp, s_lp, s_flm, s_m, s_scan} !== ev) begin
        errors++;
        $display("FAIL rstmid_restart n=%0d got=%b exp=%b", n, {s_trig, s_re, s_cp, s_lp, s_flm, s_m, s_scan}, ev);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_pattern();
    test_disable();
    test_underrun();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
